pipelined_addsub_rv: RTL
========================

// Module: pipelined_addsub_rv
// PURPOSE
//  N-bit adder/subtractor, split into STAGES carry-chained slices, one register stage per slice.
//  Successor to the fixed 32-bit pipelined sequential adder. Adds:
//   - parametrised width and depth;
//   - per-transaction add/sub mode;
//   - valid/ready backpressure on both sides.
//  Sits between producer and consumer datapaths; sustains one operation per clk with no stall.
// PARAMETERS
//  N       32  operand/result width in bits
//  STAGES  4   pipeline depth = number of slices; slice width C = N/STAGES
// PORTS
//  clk        in   1  single clock; all state updates on posedge clk
//  rstn       in   1  asynchronous, active-low reset
//  a          in   N  operand A (unsigned or two's complement)
//  b          in   N  operand B
//  cin        in   1  carry-in, used only when sub=0
//  sub        in   1  0: {cout,s}=a+b+cin; 1: {cout,s}=a+~b+1 (a-b)
//  valid_in   in   1  input transaction valid
//  ready_in   out  1  block can accept input this cycle
//  s          out  N  result
//  cout       out  1  carry-out (sub=1: 1 means no borrow, i.e. a>=b unsigned)
//  valid_out  out  1  s/cout/ovf hold a valid result
//  ready_out  in   1  consumer accepts result this cycle
//  ovf        out  1  signed overflow; present only with ADDSUB_OVF_EN
// BEHAVIOUR
//  - Elaboration: N%STAGES!=0 or STAGES<1 -> $error, no build. STAGES=1 is a registered single-cycle adder.
//  - Input transfer: valid_in && ready_in at posedge. Output transfer: valid_out && ready_out.
//  - Stage k (0..STAGES-1) computes result bits [k*C +: C] from:
//      - the stage k-1 carry;
//      - operand high bits carried forward unmodified.
//  - Stage 0 carry-in = sub ? 1 : cin; stage 0 b-inversion = sub.
//  - Per-stage valid bit v[k]. Stage k loads when !v[k] || adv[k+1]; adv[STAGES] = ready_out.
//    Bubbles collapse: an empty stage loads even when downstream is stalled.
//  - ready_in = !v[0] || adv[1]. Combinational from ready_out, allowed (no loop through inputs).
//  - Latency: STAGES cycles, accept edge to valid_out, when ready_out stays high. Throughput 1/cycle.
//  - Stall: ready_out=0 with valid_out=1 -> s/cout/ovf/valid_out held stable until transfer.
//    Upstream stages keep filling until full; then ready_in=0.
//  - Full pipeline + ready_out=1 + valid_in=1 -> simultaneous accept and emit, no bubble.
//  - Ordering strictly FIFO. No drop, no duplicate.
//  - Arithmetic modulo 2^N; cout is bit N of the exact sum. Wrap-around e.g. FFFFFFFF+1 -> s=0, cout=1.
//  - Reset (any time, incl. mid-stream):
//      - all v[k]=0; all data regs, s, cout, ovf = 0;
//      - valid_out=0; ready_in=1 from the first cycle after rstn deasserts;
//      - in-flight transactions discarded.
//  - Data regs of invalid stages are don't-care internally but never visible: outputs gated by v.
// CONFIGURATION
//  ADDSUB_OVF_EN defined:
//    - port ovf exists and travels with its result;
//    - ovf = carry into MSB XOR carry out of MSB (signed overflow of the selected op);
//    - reset 0.
//  ADDSUB_OVF_EN undefined: no ovf port, no overflow logic; all other behaviour identical.
// TESTING (N=32, STAGES=4 unless stated; reference model = delayed queue of {a,b,cin,sub})
//  1 Reset then a=283,b=50,cin=0,sub=0, ready_out=1 -> valid_out 4 cycles later, s=333, cout=0.
//  2 Stream 200 back-to-back ops:
//     - stimulus: a+=1318402, b+=182553 per cycle, random cin/sub;
//     - response: one result/cycle, all match the model, in order.
//  3 a=FFFFFFFF,b=1,cin=1,sub=0 -> s=1,cout=1; a=5,b=7,sub=1 -> s=FFFFFFFE, cout=0 (borrow).
//  4 Backpressure:
//     - stimulus: ready_out=0 for 6 cycles during a stream;
//     - response: ready_in drops after 4 accepted; outputs stable; after release, no loss/dup/reorder.
//  5 Assert rstn=0 with 3 ops in flight -> valid_out=0 immediately; after release, no stale result.
//  6 ADDSUB_OVF_EN:
//     - 7FFFFFFF+1 add -> ovf=1; 80000000-1 sub -> ovf=1;
//     - 5-7 sub -> ovf=0;
//     - rerun 1-5 with N=16,STAGES=2 and N=8,STAGES=1.

Source files
------------

// File: rtl/pipelined_addsub_rv.sv
// pipelined_addsub_rv: N-bit adder/subtractor cut into STAGES carry-chained
// slices with one register per slice and a valid/ready handshake on both ends.
// Define ADDSUB_OVF_EN to add the signed-overflow output ovf.
//
// Stage k adds slice [k*C +: C] using the carry registered by stage k-1.
// Operand bits not yet consumed travel forward untouched. Each stage keeps only
// the operand bits that later stages still need, and only the result bits
// already produced. Subtraction inverts b and forces the carry-in to 1 before
// stage 0, so every stage is a plain adder.
module pipelined_addsub_rv #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         valid_in,
  output logic         ready_in,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         valid_out,
  input  logic         ready_out
`ifdef ADDSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  // The divisor guard keeps the modulo legal while the check below rejects STAGES < 1
  localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
  localparam int C    = N / SDIV;

  if ((STAGES < 1) || ((N % SDIV) != 0)) begin : g_param_check
    $error("pipelined_addsub_rv: STAGES must be >= 1 and divide N evenly");
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    // LO: first result bit this stage produces
    // RIN: operand bits arriving here
    // SW: result bits known after this stage
    localparam int LO  = gi * C;
    localparam int RIN = N - LO;
    localparam int SW  = LO + C;

    logic [RIN-1:0] a_d;
    logic [RIN-1:0] b_d;
    logic           c_d;
    logic           v_d;
    logic           go;
    logic           go_nxt;
    logic [C:0]     slice_sum;
    logic [SW-1:0]  s_n;
    logic [SW-1:0]  s_q;
    logic           c_q;
    logic           v_q;

    if (gi == 0) begin : g_head
      // Subtraction becomes a + ~b + 1 before the first slice
      assign a_d = a;
      assign b_d = sub ? ~b : b;
      assign c_d = sub ? 1'b1 : cin;
      assign v_d = valid_in;
      assign s_n = slice_sum[C-1:0];
    end else begin : g_body
      assign a_d = g_stage[gi-1].g_fwd.a_q;
      assign b_d = g_stage[gi-1].g_fwd.b_q;
      assign c_d = g_stage[gi-1].c_q;
      assign v_d = g_stage[gi-1].v_q;
      assign s_n = {slice_sum[C-1:0], g_stage[gi-1].s_q};
    end

    // The last stage drains into the consumer. The others drain into the next stage.
    if (gi == STAGES - 1) begin : g_tail_go
      assign go_nxt = ready_out;
    end else begin : g_mid_go
      assign go_nxt = g_stage[gi+1].go;
    end

    // An empty stage always loads, so bubbles collapse even under backpressure
    assign go = !v_q || go_nxt;

    assign slice_sum = {1'b0, a_d[C-1:0]} + {1'b0, b_d[C-1:0]} + {{C{1'b0}}, c_d};

    // Stage valid, slice carry, and accumulated result bits
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (go) begin
        v_q <= v_d;
        if (v_d) begin
          c_q <= slice_sum[C];
          s_q <= s_n;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [RIN-C-1:0] a_q;
      logic [RIN-C-1:0] b_q;

      // Operand bits still owed to later slices move forward unmodified
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (go && v_d) begin
          a_q <= a_d[RIN-1:C];
          b_q <= b_d[RIN-1:C];
        end
      end
    end

`ifdef ADDSUB_OVF_EN
    if (gi == STAGES - 1) begin : g_ovf
      logic msb_cin;
      logic ovf_n;
      logic ovf_q;

      // The sum bit is a^b^carry_in, so the carry into the MSB can be recovered from it
      assign msb_cin = a_d[C-1] ^ b_d[C-1] ^ slice_sum[C-1];
      assign ovf_n   = msb_cin ^ slice_sum[C];

      // Overflow flag registered alongside its result
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          ovf_q <= 1'b0;
        end else if (go && v_d) begin
          ovf_q <= ovf_n;
        end
      end
    end
`endif
  end

  assign ready_in  = g_stage[0].go;
  assign valid_out = g_stage[STAGES-1].v_q;

  // Stale data from an empty output stage never reaches the ports
  assign s    = valid_out ? g_stage[STAGES-1].s_q : '0;
  assign cout = valid_out & g_stage[STAGES-1].c_q;
`ifdef ADDSUB_OVF_EN
  assign ovf  = valid_out & g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule
